// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam int unsigned INSTR_ALIGN_MASK = INSTR_BYTES - 1;
    localparam int unsigned MAX_OCCUPANCY    = 2;
    localparam int unsigned OCC_W            = 2;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {pc, instr} skid buffer that absorbs a fetch response arriving
// while the presented instruction is being held.
module if_skid_buffer #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] push_pc,
    input  logic [W-1:0] push_instr,
    output logic         valid,
    output logic [W-1:0] pc,
    output logic [W-1:0] instr
);

    logic         valid_q, valid_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] instr_q, instr_d;

    // Flush wins; a simultaneous push and pop replaces the entry.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (push) begin
            valid_d = 1'b1;
            pc_d    = push_pc;
            instr_d = push_instr;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, a single-outstanding imem port
// and the IF/ID producer registers (output regs plus one skid entry).
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned     size     = 32,
    parameter logic [size-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            STALL,
    input  logic            REDIRECT,
    input  logic [size-1:0] REDIRECT_PC,
    output logic            imem_req,
    output logic [size-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [size-1:0] imem_rdata,
    output logic [size-1:0] PC_IF,
    output logic [size-1:0] idata_IF,
    output logic [size-1:0] adder_IF,
    output logic            VALID_IF,
    output logic            CLEAR_IF
);

    fetch_state_t    state_q, state_d;
    logic [size-1:0] fetch_pc_q, fetch_pc_d;
    logic [size-1:0] inflight_addr_q, inflight_addr_d;
    logic [size-1:0] pc_q, pc_d;
    logic [size-1:0] idata_q, idata_d;
    logic [size-1:0] adder_q, adder_d;
    logic            valid_q, valid_d;

    logic             consume_c;
    logic             capture_c;
    logic             out_free_c;
    logic             issue_slot_c;
    logic             issue_c;
    logic [OCC_W-1:0] occ_now_c;
    logic [OCC_W-1:0] occ_next_c;

    logic            skid_push;
    logic            skid_pop;
    logic            skid_flush;
    logic            skid_valid;
    logic [size-1:0] skid_pc;
    logic [size-1:0] skid_instr;

    // Handshake terms; a response completing this cycle frees the port for a back-to-back issue.
    always_comb begin
        consume_c    = valid_q & ~STALL;
        capture_c    = (state_q == WAIT) & imem_rvalid & ~REDIRECT;
        out_free_c   = ~valid_q | consume_c;
        occ_now_c    = OCC_W'(valid_q) + OCC_W'(skid_valid);
        occ_next_c   = occ_now_c + OCC_W'(capture_c) - OCC_W'(consume_c);
        issue_slot_c = (state_q == IDLE) | ((state_q == WAIT) & imem_rvalid);
        issue_c      = ~RESET & ~REDIRECT & issue_slot_c
                     & (occ_next_c < OCC_W'(MAX_OCCUPANCY));
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a redirect with a request in flight must discard its response.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (issue_c) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = issue_c ? WAIT : IDLE;
                end else if (REDIRECT) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: the request strobe tracks this cycle's redirect/reset inputs.
    always_comb begin
        imem_req  = issue_c;
        imem_addr = fetch_pc_q;
    end

    // Fetch PC, in-flight address, output registers and skid control.
    always_comb begin
        fetch_pc_d      = fetch_pc_q;
        inflight_addr_d = inflight_addr_q;
        pc_d            = pc_q;
        idata_d         = idata_q;
        adder_d         = adder_q;
        valid_d         = valid_q;
        skid_push       = 1'b0;
        skid_pop        = 1'b0;
        skid_flush      = 1'b0;

        if (REDIRECT) begin
            fetch_pc_d = REDIRECT_PC & ~size'(INSTR_ALIGN_MASK);
            valid_d    = 1'b0;
            skid_flush = 1'b1;
        end else begin
            if (issue_c) begin
                fetch_pc_d      = fetch_pc_q + size'(INSTR_BYTES);
                inflight_addr_d = fetch_pc_q;
            end
            if (out_free_c) begin
                if (skid_valid) begin
                    // Older skid word goes out first; a new arrival takes its place.
                    pc_d      = skid_pc;
                    idata_d   = skid_instr;
                    adder_d   = skid_pc + size'(INSTR_BYTES);
                    valid_d   = 1'b1;
                    skid_pop  = 1'b1;
                    skid_push = capture_c;
                end else if (capture_c) begin
                    pc_d    = inflight_addr_q;
                    idata_d = imem_rdata;
                    adder_d = inflight_addr_q + size'(INSTR_BYTES);
                    valid_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end else begin
                skid_push = capture_c;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_pc_q      <= RESET_PC;
            inflight_addr_q <= '0;
            pc_q            <= '0;
            idata_q         <= '0;
            adder_q         <= '0;
            valid_q         <= 1'b0;
        end else begin
            fetch_pc_q      <= fetch_pc_d;
            inflight_addr_q <= inflight_addr_d;
            pc_q            <= pc_d;
            idata_q         <= idata_d;
            adder_q         <= adder_d;
            valid_q         <= valid_d;
        end
    end

    if_skid_buffer #(
        .W (size)
    ) u_skid (
        .clk        (CLK),
        .rst        (RESET),
        .push       (skid_push),
        .pop        (skid_pop),
        .flush      (skid_flush),
        .push_pc    (inflight_addr_q),
        .push_instr (imem_rdata),
        .valid      (skid_valid),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    assign PC_IF    = pc_q;
    assign idata_IF = idata_q;
    assign adder_IF = adder_q;
    assign VALID_IF = valid_q;
    assign CLEAR_IF = ~valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: behavioural memory, in-order scoreboard,
// cycle-vector tables and directed redirect/reset sequences.
module tb_if_fetch_unit;

    localparam int unsigned    W           = 32;
    localparam logic [W-1:0]   RESET_PC_TB = 32'h0;

    logic         CLK;
    logic         RESET;
    logic         STALL;
    logic         REDIRECT;
    logic [W-1:0] REDIRECT_PC;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_rvalid;
    logic [W-1:0] imem_rdata;
    logic [W-1:0] PC_IF;
    logic [W-1:0] idata_IF;
    logic [W-1:0] adder_IF;
    logic         VALID_IF;
    logic         CLEAR_IF;

    if_fetch_unit #(
        .size     (W),
        .RESET_PC (RESET_PC_TB)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .STALL       (STALL),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .PC_IF       (PC_IF),
        .idata_IF    (idata_IF),
        .adder_IF    (adder_IF),
        .VALID_IF    (VALID_IF),
        .CLEAR_IF    (CLEAR_IF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;

    // Memory model state
    int           wait_st = 0;
    bit           mem_busy = 0;
    int           mem_cnt = 0;
    logic [W-1:0] mem_a = '0;
    bit           force_stale = 0;

    // Scoreboard: addresses requested and not yet consumed, in order
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_addr = RESET_PC_TB;
    int           n_consumed = 0;
    logic [W-1:0] last_pc = '0;

    // Sampled DUT outputs
    bit           s_req, s_valid, s_clear;
    logic [W-1:0] s_addr, s_pc, s_idata, s_adder;

    typedef struct {
        bit           rst;
        int           ws;
        bit           stall;
        bit           exp_req;
        logic [W-1:0] exp_addr;
        bit           exp_valid;
        logic [W-1:0] exp_pc;
        bit           chk_rst;
    } vec_t;

    vec_t tab[$];

    function automatic logic [W-1:0] mdata(input logic [W-1:0] a);
        return a ^ 32'hC0DE_F00D ^ {a[15:0], a[31:16]};
    endfunction

    function automatic vec_t v(input bit rst, input int ws, input bit stl, input bit er,
                               input logic [W-1:0] ea, input bit ev, input logic [W-1:0] ep,
                               input bit cr);
        vec_t r;
        r.rst = rst; r.ws = ws; r.stall = stl; r.exp_req = er;
        r.exp_addr = ea; r.exp_valid = ev; r.exp_pc = ep; r.chk_rst = cr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    // One clock cycle: drive inputs and memory response, sample, score, advance.
    task automatic cycle(input bit rst, input bit stl, input bit rdr, input logic [W-1:0] rpc);
        logic [W-1:0] e;
        RESET       = rst;
        STALL       = stl;
        REDIRECT    = rdr;
        REDIRECT_PC = rpc;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (force_stale) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBAD0_BAD0;
            force_stale = 0;
        end else if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mdata(mem_a);
                mem_busy    = 0;
            end else begin
                mem_cnt--;
            end
        end
        #4;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = VALID_IF;
        s_clear = CLEAR_IF;
        s_pc    = PC_IF;
        s_idata = idata_IF;
        s_adder = adder_IF;
        if (rst) begin
            chk("req_in_reset", W'(s_req), '0);
            exp_q.delete();
            exp_addr = RESET_PC_TB;
            mem_busy = 0;
        end else begin
            chk("clear_if", W'(s_clear), W'(!s_valid));
            if (s_valid && !stl && !rdr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL consume_unexpected: PC_IF %h presented, expected nothing", s_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc_if", s_pc, e);
                    chk("idata_if", s_idata, mdata(e));
                    chk("adder_if", s_adder, e + 32'd4);
                    n_consumed++;
                    last_pc = s_pc;
                end
            end
            if (rdr) begin
                chk("req_on_redirect", W'(s_req), '0);
                exp_q.delete();
                exp_addr = rpc & ~32'd3;
            end else if (s_req) begin
                chk("req_addr", s_addr, exp_addr);
                chk("single_outstanding", W'(mem_busy), '0);
                exp_q.push_back(exp_addr);
                exp_addr = exp_addr + 32'd4;
                mem_busy = 1;
                mem_a    = s_addr;
                mem_cnt  = wait_st;
                chk("occupancy_le_2", W'(exp_q.size() <= 2), 32'd1);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_req(input string name, input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget && !ok; k++) begin
            cycle(1'b0, 1'b0, 1'b0, '0);
            if (s_req) ok = 1;
        end
        if (!ok) fail_timeout(name);
    endtask

    task automatic wait_consume(input string name, input int budget, output bit ok);
        int n0;
        n0 = n_consumed;
        ok = 0;
        for (int k = 0; k < budget && !ok; k++) begin
            cycle(1'b0, 1'b0, 1'b0, '0);
            if (n_consumed != n0) ok = 1;
        end
        if (!ok) fail_timeout(name);
    endtask

    initial begin
        bit ok;
        int n_before;

        // Zero-wait stream with a 5-cycle stall, then 3-wait-state memory.
        tab.push_back(v(1, 0, 0, 0, 32'h00, 0, 32'h00, 0));
        tab.push_back(v(1, 0, 0, 0, 32'h00, 0, 32'h00, 0));
        tab.push_back(v(0, 0, 0, 1, 32'h00, 0, 32'h00, 1));
        tab.push_back(v(0, 0, 0, 1, 32'h04, 0, 32'h00, 0));
        tab.push_back(v(0, 0, 0, 1, 32'h08, 1, 32'h00, 0));
        tab.push_back(v(0, 0, 0, 1, 32'h0C, 1, 32'h04, 0));
        for (int i = 0; i < 5; i++) tab.push_back(v(0, 0, 1, 0, 32'h00, 1, 32'h08, 0));
        tab.push_back(v(0, 0, 0, 1, 32'h10, 1, 32'h08, 0));
        tab.push_back(v(0, 0, 0, 1, 32'h14, 1, 32'h0C, 0));
        tab.push_back(v(0, 0, 0, 1, 32'h18, 1, 32'h10, 0));
        tab.push_back(v(0, 0, 0, 1, 32'h1C, 1, 32'h14, 0));
        tab.push_back(v(1, 3, 0, 0, 32'h00, 0, 32'h00, 0));
        tab.push_back(v(1, 3, 0, 0, 32'h00, 0, 32'h00, 0));
        for (int g = 0; g < 3; g++) begin
            tab.push_back(v(0, 3, 0, 1, W'(g * 4), g != 0, W'(g * 4 - 4), g == 0));
            tab.push_back(v(0, 3, 0, 0, 32'h00, 0, 32'h00, 0));
            tab.push_back(v(0, 3, 0, 0, 32'h00, 0, 32'h00, 0));
            tab.push_back(v(0, 3, 0, 0, 32'h00, 0, 32'h00, 0));
        end
        tab.push_back(v(0, 3, 0, 1, 32'h0C, 1, 32'h08, 0));
        tab.push_back(v(0, 3, 0, 0, 32'h00, 1, 32'h08, 0));

        // Group rows 1..3 above present the previous word one cycle after each
        // rvalid; patch the rows so VALID_IF pulses exactly one cycle in four.
        for (int i = 0; i < tab.size(); i++) begin
            if (!tab[i].rst && tab[i].ws == 3) begin
                tab[i].exp_valid = 0;
            end
        end
        for (int i = 0; i < tab.size(); i++) begin
            if (i > 0 && !tab[i].rst && tab[i].ws == 3 && tab[i-1].exp_req && !tab[i-1].chk_rst) begin
                tab[i].exp_valid = 1;
                tab[i].exp_pc    = tab[i-1].exp_addr - 32'd4;
            end
        end

        for (int i = 0; i < tab.size(); i++) begin
            wait_st = tab[i].ws;
            cycle(tab[i].rst, tab[i].stall, 1'b0, '0);
            if (!tab[i].rst) begin
                chk($sformatf("vec%0d_req", i), W'(s_req), W'(tab[i].exp_req));
                if (tab[i].exp_req) chk($sformatf("vec%0d_addr", i), s_addr, tab[i].exp_addr);
                chk($sformatf("vec%0d_valid", i), W'(s_valid), W'(tab[i].exp_valid));
                if (tab[i].exp_valid) begin
                    chk($sformatf("vec%0d_pc", i), s_pc, tab[i].exp_pc);
                    chk($sformatf("vec%0d_adder", i), s_adder, tab[i].exp_pc + 32'd4);
                end
                if (tab[i].chk_rst) begin
                    chk("rst_pc", s_pc, '0);
                    chk("rst_idata", s_idata, '0);
                    chk("rst_adder", s_adder, '0);
                    chk("rst_clear", W'(s_clear), 32'd1);
                end
            end
        end

        // REDIRECT + STALL + rvalid in one cycle on a zero-wait stream.
        wait_st = 0;
        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, '0);
        chk("t5_stream_req", W'(s_req), 32'd1);
        cycle(1'b0, 1'b1, 1'b1, 32'h200);
        cycle(1'b0, 1'b0, 1'b0, '0);
        chk("t5_valid_low", W'(s_valid), '0);
        chk("t5_req", W'(s_req), 32'd1);
        chk("t5_req_addr", s_addr, 32'h200);
        cycle(1'b0, 1'b0, 1'b0, '0);
        chk("t5_valid_low2", W'(s_valid), '0);
        wait_consume("t5_consume", 10, ok);
        if (ok) chk("t5_first_pc", last_pc, 32'h200);

        // Redirect to 0x100 while the 0x20 request is outstanding.
        wait_st = 2;
        cycle(1'b0, 1'b0, 1'b1, 32'h20);
        wait_req("t4_req20", 12, ok);
        if (ok) chk("t4_req20_addr", s_addr, 32'h20);
        cycle(1'b0, 1'b0, 1'b1, 32'h100);
        ok = 0;
        for (int k = 0; k < 12 && !ok; k++) begin
            cycle(1'b0, 1'b0, 1'b0, '0);
            if (s_req) begin
                ok = 1;
                chk("t4_req100_addr", s_addr, 32'h100);
            end else begin
                chk("t4_valid_low", W'(s_valid), '0);
            end
        end
        if (!ok) fail_timeout("t4_req100");
        wait_consume("t4_consume", 12, ok);
        if (ok) chk("t4_first_pc", last_pc, 32'h100);

        // Redirect to the top of the address space wraps to zero.
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        wait_req("wrap_req0", 12, ok);
        if (ok) chk("wrap_top_addr", s_addr, 32'hFFFF_FFFC);
        wait_req("wrap_req1", 12, ok);
        if (ok) chk("wrap_zero_addr", s_addr, 32'h0);

        // Reset while waiting, stale rvalid in the first cycle afterwards.
        wait_st = 3;
        wait_req("t6_req", 12, ok);
        cycle(1'b1, 1'b0, 1'b0, '0);
        force_stale = 1;
        cycle(1'b0, 1'b0, 1'b0, '0);
        chk("t6_req", W'(s_req), 32'd1);
        chk("t6_req_addr", s_addr, RESET_PC_TB);
        cycle(1'b0, 1'b0, 1'b0, '0);
        chk("t6_stale_ignored", W'(s_valid), '0);
        wait_consume("t6_consume", 12, ok);
        if (ok) chk("t6_first_pc", last_pc, RESET_PC_TB);

        // Random stalls, redirects and wait states under the scoreboard.
        n_before = n_consumed;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) wait_st = $urandom_range(0, 3);
            cycle(1'b0, $urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0, $urandom);
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, '0);
        chk("random_progress", W'(n_consumed > n_before + 50), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
